godai_trace_recorder: RTL and testbench
=======================================

GODAI_TRACE_RECORDER -- requirements
Module: godai_trace_recorder

Interface
REQ-001 The module SHALL provide parameter DEPTH, default 8, giving the number of FIFO record entries; it SHALL be a power of two and at least 2.
REQ-002 The module SHALL provide parameter TS_WIDTH, default 32, giving the timestamp width.
REQ-003 Ports SHALL be as follows; there is one clock, and reset is synchronous and active-high:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- trace_en_i  in  1  tracing enable
- instr_req_i, instr_gnt_i  in  1 each  core instruction handshake (snooped)
- instr_addr_i  in  `ADDR_WIDTH  fetch address
- data_req_i, data_gnt_i, data_we_i  in  1 each  core data handshake (snooped)
- data_addr_i  in  `ADDR_WIDTH  data address
- jump_done_i, illegal_instr_i  in  1 each  core trace strobes
- rec_valid_o  out  1  record available
- rec_ready_i  in  1  consumer accepts record
- rec_data_o  out  TS_WIDTH+4+`ADDR_WIDTH  record {timestamp, kind[3:0], addr}
- overflow_o  out  1  sticky: at least one event was dropped
- dropped_cnt_o  out  16  saturating count of dropped events
- state_o  out  2  FSM state

Function
REQ-004 The FSM SHALL have states IDLE=0, RUN=1 and DRAIN=2.
- IDLE->RUN when trace_en_i=1.
- RUN->DRAIN when trace_en_i=0.
- DRAIN->IDLE when the FIFO and all holding registers are empty.
- trace_en_i SHALL be ignored while in DRAIN.
REQ-005 Events SHALL be sampled only in RUN:
- FETCH (kind 1) on instr_req_i&instr_gnt_i, addr=instr_addr_i.
- LOAD (2) or STORE (3) on data_req_i&data_gnt_i, selected by data_we_i, addr=data_addr_i.
- JUMP (4) on jump_done_i.
- ILLEGAL (5) on illegal_instr_i.
REQ-006 JUMP and ILLEGAL records SHALL carry the address of the most recent granted fetch, held in a register that resets to 0.
REQ-007 Three one-deep holding registers, CTRL, DATA and FETCH, SHALL each capture their event together with the timestamp of the cycle in which it was sampled.
REQ-008 Within CTRL, ILLEGAL SHALL win over JUMP when both occur in the same cycle; the losing JUMP counts as dropped.
REQ-009 Each cycle, at most one holding register SHALL be written into the FIFO, with priority CTRL > DATA > FETCH.
REQ-010 A FIFO write SHALL occur only when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-011 A new event SHALL be dropped if its holding register stays occupied and is not drained in that cycle; a register drained in the same cycle SHALL accept the new event.
REQ-012 Each dropped event SHALL increment dropped_cnt_o, saturating at 0xFFFF, and SHALL set overflow_o.
REQ-013 The timestamp counter SHALL be cleared on the IDLE->RUN transition, increment every cycle in RUN and DRAIN, and wrap from 2^TS_WIDTH-1 to 0.
REQ-014 Latency SHALL be as follows: an event sampled in cycle N with the FIFO empty and no higher-priority register pending SHALL give rec_valid_o=1 in cycle N+2.
REQ-015 rec_valid_o SHALL equal FIFO not-empty.
REQ-016 A pop SHALL occur when rec_valid_o&rec_ready_i; rec_data_o SHALL hold stable while rec_valid_o=1 and rec_ready_i=0.
REQ-017 Records SHALL leave the module in FIFO order.
REQ-018 overflow_o and dropped_cnt_o SHALL hold through DRAIN and IDLE, and SHALL clear on the IDLE->RUN transition.

Reset
REQ-019 On rst=1 at a clock edge, the following SHALL hold from the next cycle:
- state IDLE
- FIFO pointers 0 and FIFO empty
- all holding registers invalid
- timestamp 0
- last-fetch address 0
- rec_valid_o=0, rec_data_o=0, overflow_o=0, dropped_cnt_o=0
REQ-020 Reset asserted mid-operation SHALL discard all buffered records without a drain.

Structure
REQ-021 Package godai_trace_pkg SHALL hold the kind encodings, the FSM state type and the record-width localparams.
REQ-022 The FIFO SHALL be a separate sub-module, godai_trace_fifo, parameterised by width and DEPTH.

Verification
REQ-023 Single fetch: RUN, fetch grant at addr 0x80 in cycle 3 -> in cycle 5, rec_valid_o=1 and the record is {ts=3, kind=1, addr=0x80}.
REQ-024 Simultaneous events: in one cycle, a data store grant at 0x1000 and a fetch grant at 0x84 -> STORE output first, then FETCH, both with the same timestamp, and dropped_cnt_o=0.
REQ-025 Back-pressure: rec_ready_i=0 and fetch grants every cycle for 12 cycles with DEPTH=8 -> 8 records stored, 1 held in FETCH, 3 dropped, overflow_o=1, and rec_data_o stable throughout.
REQ-026 ILLEGAL and JUMP in the same cycle, last fetch addr 0x20 -> one record {kind=5, addr=0x20} and dropped_cnt_o=1.
REQ-027 Drain: trace_en_i deasserted with 4 records buffered and rec_ready_i=1 -> state DRAIN, 4 records popped, then IDLE; a fetch grant during DRAIN is not recorded.
REQ-028 Mid-operation reset: rst=1 for 1 cycle with records buffered -> rec_valid_o=0 and state IDLE in the next cycle.

Source files
------------

// File: rtl/godai_trace_pkg.sv
// Shared definitions for the trace recorder: record kinds, FSM states and record field widths.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package godai_trace_pkg;

    localparam int ADDR_WIDTH   = `ADDR_WIDTH;
    localparam int KIND_W       = 4;
    localparam int TS_WIDTH_DEF = 32;
    localparam int REC_W_DEF    = TS_WIDTH_DEF + KIND_W + ADDR_WIDTH;

    typedef enum logic [KIND_W-1:0] {
        KIND_NONE    = 4'd0,
        KIND_FETCH   = 4'd1,
        KIND_LOAD    = 4'd2,
        KIND_STORE   = 4'd3,
        KIND_JUMP    = 4'd4,
        KIND_ILLEGAL = 4'd5
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/godai_trace_fifo.sv
// Record FIFO with extra-bit pointers; output reads as zero while empty so idle data is clean.
module godai_trace_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr_q;
    logic [PW:0]      rptr_q;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign rdata = empty ? '0 : mem[rptr_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + (PW+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/godai_trace_recorder.sv
// Snoops core handshakes, buffers trace events in three holding registers and
// funnels them into a record FIFO with CTRL > DATA > FETCH priority.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | tracing off, counters/flags hold, waiting for trace_en_i
//   ST_RUN   | events sampled, timestamp counting
//   ST_DRAIN | no sampling, flushing holding registers and FIFO
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module godai_trace_recorder
    import godai_trace_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   trace_en_i,
    input  logic                                   instr_req_i,
    input  logic                                   instr_gnt_i,
    input  logic [`ADDR_WIDTH-1:0]                 instr_addr_i,
    input  logic                                   data_req_i,
    input  logic                                   data_gnt_i,
    input  logic                                   data_we_i,
    input  logic [`ADDR_WIDTH-1:0]                 data_addr_i,
    input  logic                                   jump_done_i,
    input  logic                                   illegal_instr_i,
    output logic                                   rec_valid_o,
    input  logic                                   rec_ready_i,
    output logic [TS_WIDTH+KIND_W+`ADDR_WIDTH-1:0] rec_data_o,
    output logic                                   overflow_o,
    output logic [15:0]                            dropped_cnt_o,
    output logic [1:0]                             state_o
);

    localparam int REC_W = TS_WIDTH + KIND_W + ADDR_WIDTH;

    state_t state_q, state_d;

    logic [TS_WIDTH-1:0]   ts_q;
    logic [ADDR_WIDTH-1:0] last_fetch_q;

    logic                  ctrl_v_q,  data_v_q,  fetch_v_q;
    logic [TS_WIDTH-1:0]   ctrl_ts_q, data_ts_q, fetch_ts_q;
    logic [ADDR_WIDTH-1:0] ctrl_addr_q, data_addr_q, fetch_addr_q;
    kind_t                 ctrl_kind_q, data_kind_q;

    logic        overflow_q;
    logic [15:0] drop_cnt_q;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [REC_W-1:0] fifo_wdata;

    logic start_run, sampling, holds_empty;
    logic ev_fetch, ev_data, ev_jump, ev_ill, ev_ctrl;
    logic sel_ctrl, sel_data, sel_fetch;
    logic ctrl_room, data_room, fetch_room;
    logic [2:0]  n_drop;
    logic [16:0] drop_sum;
    logic [15:0] drop_next;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (trace_en_i) state_d = ST_RUN;
            ST_RUN:   if (!trace_en_i) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && holds_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign start_run   = (state_q == ST_IDLE) && trace_en_i;
    assign sampling    = (state_q == ST_RUN);
    assign holds_empty = ~(ctrl_v_q | data_v_q | fetch_v_q);

    assign ev_fetch = sampling & instr_req_i & instr_gnt_i;
    assign ev_data  = sampling & data_req_i & data_gnt_i;
    assign ev_jump  = sampling & jump_done_i;
    assign ev_ill   = sampling & illegal_instr_i;
    assign ev_ctrl  = ev_jump | ev_ill;

    assign sel_ctrl  = ctrl_v_q;
    assign sel_data  = data_v_q & ~ctrl_v_q;
    assign sel_fetch = fetch_v_q & ~ctrl_v_q & ~data_v_q;

    assign fifo_pop  = ~fifo_empty & rec_ready_i;
    assign fifo_push = ~holds_empty & (~fifo_full | fifo_pop);

    // A register emptied into the FIFO this cycle can take a new event at the same edge.
    assign ctrl_room  = ~ctrl_v_q  | (sel_ctrl  & fifo_push);
    assign data_room  = ~data_v_q  | (sel_data  & fifo_push);
    assign fetch_room = ~fetch_v_q | (sel_fetch & fifo_push);

    always_comb begin
        fifo_wdata = {fetch_ts_q, KIND_FETCH, fetch_addr_q};
        if (sel_ctrl) begin
            fifo_wdata = {ctrl_ts_q, ctrl_kind_q, ctrl_addr_q};
        end else if (sel_data) begin
            fifo_wdata = {data_ts_q, data_kind_q, data_addr_q};
        end
    end

    assign n_drop = {2'b0, ev_ill & ev_jump}
                  + {2'b0, ev_ctrl  & ~ctrl_room}
                  + {2'b0, ev_data  & ~data_room}
                  + {2'b0, ev_fetch & ~fetch_room};

    assign drop_sum  = {1'b0, drop_cnt_q} + {14'b0, n_drop};
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ts_q         <= '0;
            last_fetch_q <= '0;
            ctrl_v_q     <= 1'b0;
            data_v_q     <= 1'b0;
            fetch_v_q    <= 1'b0;
            ctrl_ts_q    <= '0;
            data_ts_q    <= '0;
            fetch_ts_q   <= '0;
            ctrl_addr_q  <= '0;
            data_addr_q  <= '0;
            fetch_addr_q <= '0;
            ctrl_kind_q  <= KIND_NONE;
            data_kind_q  <= KIND_NONE;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q <= state_d;

            if (start_run) begin
                ts_q <= '0;
            end else if (state_q != ST_IDLE) begin
                ts_q <= ts_q + TS_WIDTH'(1);
            end

            if (ev_fetch) begin
                last_fetch_q <= instr_addr_i;
            end

            // Control records take the fetch address as it stood before this cycle's grant.
            if (ev_ctrl && ctrl_room) begin
                ctrl_v_q    <= 1'b1;
                ctrl_ts_q   <= ts_q;
                ctrl_kind_q <= ev_ill ? KIND_ILLEGAL : KIND_JUMP;
                ctrl_addr_q <= last_fetch_q;
            end else if (sel_ctrl && fifo_push) begin
                ctrl_v_q <= 1'b0;
            end

            if (ev_data && data_room) begin
                data_v_q    <= 1'b1;
                data_ts_q   <= ts_q;
                data_kind_q <= data_we_i ? KIND_STORE : KIND_LOAD;
                data_addr_q <= data_addr_i;
            end else if (sel_data && fifo_push) begin
                data_v_q <= 1'b0;
            end

            if (ev_fetch && fetch_room) begin
                fetch_v_q    <= 1'b1;
                fetch_ts_q   <= ts_q;
                fetch_addr_q <= instr_addr_i;
            end else if (sel_fetch && fifo_push) begin
                fetch_v_q <= 1'b0;
            end

            if (start_run) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (n_drop != 3'd0) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_next;
            end
        end
    end

    godai_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (rec_data_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rec_valid_o   = ~fifo_empty;
    assign overflow_o    = overflow_q;
    assign dropped_cnt_o = drop_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_godai_trace_recorder.sv
// Trace recorder bench: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_godai_trace_recorder;
    import godai_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int TSW   = 32;
    localparam int AW    = ADDR_WIDTH;
    localparam int RW    = TSW + KIND_W + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trace_en_i = 1'b0;
    logic          instr_req_i = 1'b0, instr_gnt_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic          data_req_i = 1'b0, data_gnt_i = 1'b0, data_we_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic          jump_done_i = 1'b0, illegal_instr_i = 1'b0;
    logic          rec_valid_o;
    logic          rec_ready_i = 1'b0;
    logic [RW-1:0] rec_data_o;
    logic          overflow_o;
    logic [15:0]   dropped_cnt_o;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    godai_trace_recorder #(.DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk             (clk),
        .rst             (rst),
        .trace_en_i      (trace_en_i),
        .instr_req_i     (instr_req_i),
        .instr_gnt_i     (instr_gnt_i),
        .instr_addr_i    (instr_addr_i),
        .data_req_i      (data_req_i),
        .data_gnt_i      (data_gnt_i),
        .data_we_i       (data_we_i),
        .data_addr_i     (data_addr_i),
        .jump_done_i     (jump_done_i),
        .illegal_instr_i (illegal_instr_i),
        .rec_valid_o     (rec_valid_o),
        .rec_ready_i     (rec_ready_i),
        .rec_data_o      (rec_data_o),
        .overflow_o      (overflow_o),
        .dropped_cnt_o   (dropped_cnt_o),
        .state_o         (state_o)
    );

    typedef struct packed {
        logic          rst, en, ireq, ignt;
        logic [AW-1:0] iaddr;
        logic          dreq, dgnt, dwe;
        logic [AW-1:0] daddr;
        logic          jmp, ill, rdy;
    } stim_t;

    typedef struct packed {
        logic           v;
        logic [TSW-1:0] ts;
        logic [3:0]     kind;
        logic [AW-1:0]  addr;
    } slot_t;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 run, 2 drain
    int             m_state;
    logic [TSW-1:0] m_ts;
    logic [AW-1:0]  m_last;
    slot_t          m_ctrl, m_data, m_fetch;
    logic [RW-1:0]  m_fifo[$];
    logic           m_ovf;
    int             m_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] make_rec(input logic [TSW-1:0] ts, input logic [3:0] kind,
                                               input logic [AW-1:0] addr);
        return {ts, kind, addr};
    endfunction

    function automatic stim_t idle_stim(input logic en, input logic rdy);
        stim_t t;
        t     = '0;
        t.en  = en;
        t.rdy = rdy;
        return t;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ts    = '0;
        m_last  = '0;
        m_ctrl  = '0;
        m_data  = '0;
        m_fetch = '0;
        m_fifo.delete();
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input stim_t t);
        logic done;
        int   drops;
        if (t.rst) begin
            model_reset();
            return;
        end
        done  = (m_fifo.size() == 0) && !m_ctrl.v && !m_data.v && !m_fetch.v;
        drops = 0;
        if (m_fifo.size() > 0 && t.rdy) void'(m_fifo.pop_front());
        if (m_fifo.size() < DEPTH) begin
            if (m_ctrl.v) begin
                m_fifo.push_back(make_rec(m_ctrl.ts, m_ctrl.kind, m_ctrl.addr));
                m_ctrl.v = 1'b0;
            end else if (m_data.v) begin
                m_fifo.push_back(make_rec(m_data.ts, m_data.kind, m_data.addr));
                m_data.v = 1'b0;
            end else if (m_fetch.v) begin
                m_fifo.push_back(make_rec(m_fetch.ts, 4'd1, m_fetch.addr));
                m_fetch.v = 1'b0;
            end
        end
        if (m_state == 1) begin
            if (t.ill || t.jmp) begin
                if (t.ill && t.jmp) drops++;
                if (m_ctrl.v) drops++;
                else m_ctrl = '{1'b1, m_ts, (t.ill ? 4'd5 : 4'd4), m_last};
            end
            if (t.dreq && t.dgnt) begin
                if (m_data.v) drops++;
                else m_data = '{1'b1, m_ts, (t.dwe ? 4'd3 : 4'd2), t.daddr};
            end
            if (t.ireq && t.ignt) begin
                if (m_fetch.v) drops++;
                else m_fetch = '{1'b1, m_ts, 4'd1, t.iaddr};
                m_last = t.iaddr;
            end
        end
        if (drops > 0) begin
            m_ovf = 1'b1;
            m_cnt = (m_cnt + drops > 65535) ? 65535 : m_cnt + drops;
        end
        case (m_state)
            0: if (t.en) begin m_state = 1; m_ts = '0; m_ovf = 1'b0; m_cnt = 0; end
            1: begin m_ts = m_ts + 1; if (!t.en) m_state = 2; end
            default: begin m_ts = m_ts + 1; if (done) m_state = 0; end
        endcase
    endtask

    task automatic compare_all();
        check("state", 128'(state_o), 128'(m_state));
        check("valid", 128'(rec_valid_o), 128'(m_fifo.size() > 0));
        check("data", 128'(rec_data_o), (m_fifo.size() > 0) ? 128'(m_fifo[0]) : 128'(0));
        check("overflow", 128'(overflow_o), 128'(m_ovf));
        check("dropped", 128'(dropped_cnt_o), 128'(m_cnt));
    endtask

    task automatic cycle(input stim_t t);
        rst             = t.rst;
        trace_en_i      = t.en;
        instr_req_i     = t.ireq;
        instr_gnt_i     = t.ignt;
        instr_addr_i    = t.iaddr;
        data_req_i      = t.dreq;
        data_gnt_i      = t.dgnt;
        data_we_i       = t.dwe;
        data_addr_i     = t.daddr;
        jump_done_i     = t.jmp;
        illegal_instr_i = t.ill;
        rec_ready_i     = t.rdy;
        model_step(t);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int    pops;
        logic  en_r;
        int    rdy_pct;

        model_reset();
        @(negedge clk);
        s = idle_stim(1'b0, 1'b0);
        s.rst = 1'b1;
        cycle(s);
        cycle(s);

        // single fetch: RUN cycle 3 grant at 0x80, record visible in cycle 5
        s = idle_stim(1'b1, 1'b0);
        repeat (4) cycle(s);
        s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h80;
        cycle(s);
        check("single_early", 128'(rec_valid_o), 128'(0));
        cycle(idle_stim(1'b1, 1'b0));
        check("single_valid", 128'(rec_valid_o), 128'(1));
        check("single_rec", 128'(rec_data_o), 128'(make_rec(32'd3, 4'd1, 32'h80)));
        cycle(idle_stim(1'b1, 1'b1));

        // store + fetch in RUN cycle 6
        s = idle_stim(1'b1, 1'b1);
        s.dreq = 1'b1; s.dgnt = 1'b1; s.dwe = 1'b1; s.daddr = 32'h1000;
        s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h84;
        cycle(s);
        cycle(idle_stim(1'b1, 1'b1));
        check("simul_first", 128'(rec_data_o), 128'(make_rec(32'd6, 4'd3, 32'h1000)));
        cycle(idle_stim(1'b1, 1'b1));
        check("simul_second", 128'(rec_data_o), 128'(make_rec(32'd6, 4'd1, 32'h84)));
        check("simul_drops", 128'(dropped_cnt_o), 128'(0));
        cycle(idle_stim(1'b1, 1'b1));

        // fetch 0x20 in cycle 10, illegal+jump in cycle 11
        s = idle_stim(1'b1, 1'b1);
        s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h20;
        cycle(s);
        s = idle_stim(1'b1, 1'b1);
        s.ill = 1'b1; s.jmp = 1'b1;
        cycle(s);
        cycle(idle_stim(1'b1, 1'b1));
        check("ill_rec", 128'(rec_data_o), 128'(make_rec(32'd11, 4'd5, 32'h20)));
        check("ill_drops", 128'(dropped_cnt_o), 128'(1));
        cycle(idle_stim(1'b1, 1'b1));

        // drain with 4 buffered records; a fetch offered during DRAIN is ignored
        for (int i = 0; i < 4; i++) begin
            s = idle_stim(1'b1, 1'b0);
            s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h200 + 32'(4 * i);
            cycle(s);
        end
        cycle(idle_stim(1'b1, 1'b0));
        cycle(idle_stim(1'b1, 1'b0));
        pops = rec_valid_o ? 1 : 0;
        cycle(idle_stim(1'b0, 1'b1));
        check("drain_state", 128'(state_o), 128'(2));
        for (int i = 0; i < 30 && state_o != 2'd0; i++) begin
            if (rec_valid_o) pops++;
            s = idle_stim(i == 0, 1'b1);
            if (i == 0) begin s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h300; end
            cycle(s);
        end
        check("drain_idle", 128'(state_o), 128'(0));
        check("drain_pops", 128'(pops), 128'(4));
        check("idle_drops_hold", 128'(dropped_cnt_o), 128'(1));
        check("idle_ovf_hold", 128'(overflow_o), 128'(1));
        cycle(idle_stim(1'b1, 1'b0));
        check("restart_drops", 128'(dropped_cnt_o), 128'(0));
        check("restart_ovf", 128'(overflow_o), 128'(0));

        // back-pressure: 12 fetch grants, ready low
        for (int i = 0; i < 12; i++) begin
            s = idle_stim(1'b1, 1'b0);
            s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h400 + 32'(4 * i);
            cycle(s);
            if (i >= 1) begin
                check("bp_valid", 128'(rec_valid_o), 128'(1));
                check("bp_hold", 128'(rec_data_o), 128'(make_rec(32'd0, 4'd1, 32'h400)));
            end
        end
        cycle(idle_stim(1'b1, 1'b0));
        cycle(idle_stim(1'b1, 1'b0));
        check("bp_hold_end", 128'(rec_data_o), 128'(make_rec(32'd0, 4'd1, 32'h400)));
        check("bp_drops", 128'(dropped_cnt_o), 128'(3));
        check("bp_ovf", 128'(overflow_o), 128'(1));
        pops = 0;
        for (int i = 0; i < 20 && rec_valid_o; i++) begin
            pops++;
            cycle(idle_stim(1'b1, 1'b1));
        end
        check("bp_pops", 128'(pops), 128'(9));

        // mid-operation reset with records buffered
        for (int i = 0; i < 3; i++) begin
            s = idle_stim(1'b1, 1'b0);
            s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = 32'h500 + 32'(4 * i);
            cycle(s);
        end
        cycle(idle_stim(1'b1, 1'b0));
        check("pre_rst_valid", 128'(rec_valid_o), 128'(1));
        s = idle_stim(1'b1, 1'b0);
        s.rst = 1'b1;
        cycle(s);
        check("rst_valid", 128'(rec_valid_o), 128'(0));
        check("rst_state", 128'(state_o), 128'(0));
        check("rst_data", 128'(rec_data_o), 128'(0));

        // saturate the drop counter: every event every cycle, no consumer
        cycle(idle_stim(1'b1, 1'b0));
        for (int i = 0; i < 16500; i++) begin
            s = idle_stim(1'b1, 1'b0);
            s.ireq = 1'b1; s.ignt = 1'b1; s.iaddr = $urandom;
            s.dreq = 1'b1; s.dgnt = 1'b1; s.dwe = 1'($urandom_range(0, 1)); s.daddr = $urandom;
            s.jmp = 1'b1; s.ill = 1'b1;
            cycle(s);
        end
        check("sat_drops", 128'(dropped_cnt_o), 128'(16'hFFFF));
        check("sat_ovf", 128'(overflow_o), 128'(1));

        // random traffic
        en_r    = 1'b1;
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 60 : 100);
            if ($urandom_range(0, 99) < 3) en_r = ~en_r;
            s       = idle_stim(en_r, 1'($urandom_range(0, 99) < rdy_pct));
            s.ireq  = 1'($urandom_range(0, 1));
            s.ignt  = 1'($urandom_range(0, 1));
            s.iaddr = $urandom;
            s.dreq  = 1'($urandom_range(0, 1));
            s.dgnt  = 1'($urandom_range(0, 1));
            s.dwe   = 1'($urandom_range(0, 1));
            s.daddr = $urandom;
            s.jmp   = 1'($urandom_range(0, 99) < 15);
            s.ill   = 1'($urandom_range(0, 99) < 8);
            s.rst   = 1'($urandom_range(0, 999) == 0);
            cycle(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
